// File: rtl/jtframe_db15_tx.sv
// jtframe_db15_tx
// Serializes the player controls onto a DB15-style shift-register link. The
// reading host pulls joy_load low to latch the controls, releases it, then
// clocks the bits out on joy_clk rising edges. Buttons go out active-low.
//
// Configuration macro: JTFRAME_DB15_TX_2P_EN
//   defined   -> 24-bit frame, joy1 bit0..11 followed by joy2 bit0..11
//   undefined -> 12-bit frame, joy1 only, joy2 ignored
//
// Parameters
//   TIMEOUT      clk_sys cycles with no joy_clk rising edge before a frame
//                in progress is abandoned
//   SYNC_STAGES  synchronizer depth for joy_clk / joy_load (2..3)
//
// Ports
//   clk_sys      system clock
//   RESET        asynchronous active-high reset
//   joy1, joy2   controls, active-high (0 up,1 down,2 left,3 right,
//                4..9 B1..B6, 10 start, 11 coin)
//   joy_clk      host shift clock, asynchronous
//   joy_load     host load strobe, active-low, asynchronous
//   joy_data     serial data, 0 = pressed, idles at 1
//   busy         frame loaded and not yet completed or abandoned
//   frame_done   one-cycle pulse when the last bit is consumed
//   timeout_err  one-cycle pulse when the watchdog abandons a frame
//   debug_state  current FSM state (IDLE=0, LOAD=1, SHIFT=2)
//
// Host handshake: joy_load low loads (and keeps reloading) the controls;
// its rising edge freezes the word. Each joy_clk rising edge while joy_load
// is high consumes one bit; joy_data always shows the next unconsumed bit.
module jtframe_db15_tx #(
    parameter logic [15:0] TIMEOUT     = 16'd50000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic [11:0] joy1,
    input  logic [11:0] joy2,
    input  logic        joy_clk,
    input  logic        joy_load,
    output logic        joy_data,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout_err,
    output logic [1:0]  debug_state
);

`ifdef JTFRAME_DB15_TX_2P_EN
    localparam int W = 24;
    logic [W-1:0] word;
    assign word = ~{joy2, joy1};
`else
    localparam int W = 12;
    logic [W-1:0] word;
    logic         unused_joy2;
    assign word        = ~joy1;
    assign unused_joy2 = ^joy2;
`endif

    localparam logic [4:0] FRAME_BITS = 5'(W);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;

    logic [1:0]             state;
    logic [SYNC_STAGES-1:0] clk_sync, load_sync;
    logic                   clk_prev;
    logic                   clk_s, load_s, clk_rise;
    logic [W-1:0]           sr;
    logic [4:0]             cnt;
    logic [15:0]            wd;

    // Synchronizers reset to 1 so that releasing RESET never looks like an
    // edge or a load request.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            clk_sync  <= '1;
            load_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], joy_clk};
            load_sync <= {load_sync[SYNC_STAGES-2:0], joy_load};
            clk_prev  <= clk_s;
        end
    end

    assign clk_s       = clk_sync[SYNC_STAGES-1];
    assign load_s      = load_sync[SYNC_STAGES-1];
    assign clk_rise    = clk_s & ~clk_prev;
    assign debug_state = state;

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            sr          <= '1;
            cnt         <= 5'd0;
            wd          <= 16'd0;
            joy_data    <= 1'b1;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    joy_data <= 1'b1;
                    busy     <= 1'b0;
                    wd       <= 16'd0;
                    if (!load_s) state <= LOAD;
                end
                LOAD: begin
                    busy <= 1'b1;
                    wd   <= 16'd0;
                    cnt  <= 5'd0;
                    // In LOAD, load_s high can only be its rising edge: the
                    // word loaded on the previous cycles stays frozen.
                    if (load_s) begin
                        state <= SHIFT;
                    end else begin
                        sr       <= word;
                        joy_data <= word[0];
                    end
                end
                SHIFT: begin
                    busy <= 1'b1;
                    // A load request outranks any coincident shift edge.
                    if (!load_s) begin
                        state <= LOAD;
                        wd    <= 16'd0;
                    end else if (clk_rise) begin
                        sr  <= {1'b1, sr[W-1:1]};
                        cnt <= cnt + 5'd1;
                        wd  <= 16'd0;
                        if (cnt + 5'd1 == FRAME_BITS) begin
                            frame_done <= 1'b1;
                            joy_data   <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            joy_data <= sr[1];
                        end
                    end else if (wd + 16'd1 == TIMEOUT) begin
                        timeout_err <= 1'b1;
                        joy_data    <= 1'b1;
                        busy        <= 1'b0;
                        wd          <= 16'd0;
                        state       <= IDLE;
                    end else begin
                        wd <= wd + 16'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    joy_data <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_db15_tx.sv
// Directed bench for jtframe_db15_tx (TIMEOUT=100, SYNC_STAGES=2).
// Host-side signals change on clk_sys falling edges; outputs are sampled
// on falling edges, away from the active edge.
module tb_jtframe_db15_tx;

`ifdef JTFRAME_DB15_TX_2P_EN
    localparam int FB = 24;
`else
    localparam int FB = 12;
`endif

    logic        clk_sys = 1'b0;
    logic        RESET;
    logic [11:0] joy1, joy2;
    logic        joy_clk, joy_load;
    logic        joy_data, busy, frame_done, timeout_err;
    logic [1:0]  debug_state;

    int vectors = 0;
    int fails   = 0;
    int fd_cnt  = 0;
    int to_cnt  = 0;
    int fd_base, to_base, n;
    logic [23:0] exp_w;

    jtframe_db15_tx #(.TIMEOUT(16'd100), .SYNC_STAGES(2)) dut (
        .clk_sys     (clk_sys),
        .RESET       (RESET),
        .joy1        (joy1),
        .joy2        (joy2),
        .joy_clk     (joy_clk),
        .joy_load    (joy_load),
        .joy_data    (joy_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err),
        .debug_state (debug_state)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (frame_done)  fd_cnt <= fd_cnt + 1;
        if (timeout_err) to_cnt <= to_cnt + 1;
    end

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int k);
        repeat (k) @(negedge clk_sys);
    endtask

    task automatic do_load();
        joy_load = 1'b0;
        cycles(6);
        joy_load = 1'b1;
        cycles(6);
    endtask

    task automatic clk_pulse();
        joy_clk = 1'b1;
        cycles(4);
        joy_clk = 1'b0;
        cycles(4);
    endtask

    // Sample every bit of a frame (before each clock) against exp_w.
    task automatic run_frame(input string tag);
        for (int i = 0; i < FB; i++) begin
            check(tag, 24'(joy_data), 24'(exp_w[i]));
            clk_pulse();
        end
    endtask

    initial begin
        RESET = 1'b1; joy1 = '0; joy2 = '0; joy_clk = 1'b0; joy_load = 1'b1;
        cycles(3);
        check("rst_data",  24'(joy_data), 24'd1);
        check("rst_busy",  24'(busy), 24'd0);
        check("rst_fd",    24'(frame_done), 24'd0);
        check("rst_to",    24'(timeout_err), 24'd0);
        check("rst_state", 24'(debug_state), 24'd0);
        RESET = 1'b0;
        cycles(3);

        // Clocks in IDLE are ignored.
        fd_base = fd_cnt;
        clk_pulse(); clk_pulse();
        check("idle_data", 24'(joy_data), 24'd1);
        check("idle_fd",   24'(fd_cnt - fd_base), 24'd0);

        // Single pressed up on joy1: one 0 then all ones.
        joy1 = 12'h001; joy2 = 12'h000;
        fd_base = fd_cnt;
        do_load();
        check("f1_busy",  24'(busy), 24'd1);
        check("f1_state", 24'(debug_state), 24'd2);
        exp_w = 24'hFFFFFE;
        run_frame("f1_bit");
        check("f1_fd",   24'(fd_cnt - fd_base), 24'd1);
        check("f1_data", 24'(joy_data), 24'd1);
        check("f1_busy_end", 24'(busy), 24'd0);

        // Pattern frame; joy1 changes mid-frame must not matter.
        // ~{3C3,A5A} = C3C5A5
        joy1 = 12'hA5A; joy2 = 12'h3C3;
        fd_base = fd_cnt;
        do_load();
        exp_w = 24'hC3C5A5;
        for (int i = 0; i < FB; i++) begin
            check("f2_bit", 24'(joy_data), 24'(exp_w[i]));
            clk_pulse();
            if (i == 2) begin joy1 = 12'h000; joy2 = 12'hFFF; end
        end
        check("f2_fd", 24'(fd_cnt - fd_base), 24'd1);
        clk_pulse();
        check("f2_extra_data", 24'(joy_data), 24'd1);
        check("f2_extra_fd", 24'(fd_cnt - fd_base), 24'd1);

        // Load while joy_clk toggles: load wins, no shift.
        joy1 = 12'h002; joy2 = 12'h000;
        joy_load = 1'b0;
        cycles(6);
        clk_pulse();
        joy_load = 1'b1;
        cycles(6);
        check("coinc_bit0", 24'(joy_data), 24'd1);
        clk_pulse();
        check("coinc_bit1", 24'(joy_data), 24'd0);

        // Watchdog: reload, 5 clocks, then silence.
        joy1 = 12'h000;
        fd_base = fd_cnt; to_base = to_cnt;
        do_load();
        repeat (4) clk_pulse();
        joy_clk = 1'b1;
        n = 0;
        while (n < 300) begin
            @(negedge clk_sys);
            n++;
            if (n == 4) joy_clk = 1'b0;
            if (timeout_err) break;
        end
        check("to_latency", 24'(n), 24'd103);
        check("to_fd_excl", 24'(frame_done), 24'd0);
        @(negedge clk_sys);
        check("to_pulse_len", 24'(timeout_err), 24'd0);
        check("to_busy", 24'(busy), 24'd0);
        check("to_data", 24'(joy_data), 24'd1);
        check("to_count", 24'(to_cnt - to_base), 24'd1);
        check("to_no_fd", 24'(fd_cnt - fd_base), 24'd0);

        // Early restart after 10 clocks with joy1 all pressed.
        joy1 = 12'h000; joy2 = 12'h000;
        fd_base = fd_cnt; to_base = to_cnt;
        do_load();
        repeat (10) clk_pulse();
        joy1 = 12'hFFF;
        do_load();
        check("rl_no_fd", 24'(fd_cnt - fd_base), 24'd0);
        check("rl_no_to", 24'(to_cnt - to_base), 24'd0);
        exp_w = 24'hFFF000;
        run_frame("rl_bit");
        check("rl_fd", 24'(fd_cnt - fd_base), 24'd1);

        // Reset mid-frame.
        joy1 = 12'h0F0;
        fd_base = fd_cnt; to_base = to_cnt;
        do_load();
        repeat (7) clk_pulse();
        RESET = 1'b1;
        #1;
        check("mr_data_async", 24'(joy_data), 24'd1);
        check("mr_busy_async", 24'(busy), 24'd0);
        cycles(2);
        RESET = 1'b0;
        cycles(2);
        check("mr_state", 24'(debug_state), 24'd0);
        check("mr_fd", 24'(frame_done), 24'd0);
        check("mr_to", 24'(timeout_err), 24'd0);
        for (int i = 0; i < 3; i++) begin
            clk_pulse();
            check("mr_noload_data", 24'(joy_data), 24'd1);
            check("mr_noload_busy", 24'(busy), 24'd0);
        end
        check("mr_fd_cnt", 24'(fd_cnt - fd_base), 24'd0);
        check("mr_to_cnt", 24'(to_cnt - to_base), 24'd0);

`ifndef JTFRAME_DB15_TX_2P_EN
        // Single-player frame: coin on bit 11, joy2 invisible.
        joy1 = 12'h800; joy2 = 12'hFFF;
        fd_base = fd_cnt;
        do_load();
        exp_w = 24'hFFF7FF;
        for (int i = 0; i < 11; i++) begin
            check("p1_bit", 24'(joy_data), 24'(exp_w[i]));
            clk_pulse();
            check("p1_no_early_fd", 24'(fd_cnt - fd_base), 24'd0);
        end
        check("p1_bit11", 24'(joy_data), 24'd0);
        clk_pulse();
        check("p1_fd", 24'(fd_cnt - fd_base), 24'd1);
        joy2 = 12'h5A5;
        clk_pulse();
        check("p1_after_data", 24'(joy_data), 24'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
